// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - load/store sequencer between the MEM stage and the data-memory bus
module riscv_lsu_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic [2:0]       req_func3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             lsu_stall,
    output logic             resp_valid,
    output logic [WIDTH-1:0] load_data,
    output logic             acc_err,
    output logic             bus_valid,
    input  logic             bus_ready,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [7:0]       bus_wstrb,
    input  logic             bus_rvalid,
    input  logic [WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_write;
    logic [2:0]       r_func3;
    logic [2:0]       r_off;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [7:0]       r_wstrb;
    logic [WIDTH-1:0] r_load_data;
    logic             r_err;

    logic [2:0]       w_off;
    logic             w_misalign;
    logic             w_illegal;
    logic [7:0]       w_strb;
    logic [WIDTH-1:0] w_lane;
    logic [WIDTH-1:0] w_ext;

    assign w_off = req_addr[2:0];

    // Alignment requirement follows the access size encoded in funct3[1:0].
    always_comb begin
        w_misalign = 1'b0;
        w_strb     = 8'h00;
        case (req_func3[1:0])
            2'b00: begin w_misalign = 1'b0;        w_strb = 8'h01 << w_off; end
            2'b01: begin w_misalign = w_off[0];    w_strb = 8'h03 << w_off; end
            2'b10: begin w_misalign = |w_off[1:0]; w_strb = 8'h0F << w_off; end
            default: begin w_misalign = |w_off;    w_strb = 8'hFF;          end
        endcase
        w_illegal = w_misalign | (req_write ? req_func3[2] : (req_func3 == 3'b111));
    end

    assign w_lane = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = '0;
        case (r_func3)
            3'b000: w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001: w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010: w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b011: w_ext = w_lane;
            3'b100: w_ext = {56'd0, w_lane[7:0]};
            3'b101: w_ext = {48'd0, w_lane[15:0]};
            3'b110: w_ext = {32'd0, w_lane[31:0]};
            default: w_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_illegal ? S_DONE : S_REQ;
            S_REQ:   if (bus_ready) w_next = S_WAIT;
            S_WAIT:  if (bus_rvalid) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_func3     <= 3'd0;
            r_off       <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 8'h00;
            r_load_data <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_write     <= req_write;
                r_func3     <= req_func3;
                r_off       <= w_off;
                r_addr      <= {req_addr[WIDTH-1:3], 3'b000};
                r_wdata     <= req_write ? (req_wdata << {w_off, 3'b000}) : '0;
                r_wstrb     <= (req_write && !w_illegal) ? w_strb : 8'h00;
                r_load_data <= '0;
                r_err       <= w_illegal;
            end
            // Stores use rvalid only as the write acknowledge; their rdata is discarded.
            if (r_state == S_WAIT && bus_rvalid && !r_write) begin
                r_load_data <= w_ext;
            end
        end
    end

    always_comb begin
        bus_valid  = (r_state == S_REQ);
        bus_we     = bus_valid & r_write;
        bus_addr   = bus_valid ? r_addr  : '0;
        bus_wdata  = bus_valid ? r_wdata : '0;
        bus_wstrb  = bus_valid ? r_wstrb : 8'h00;
        resp_valid = (r_state == S_DONE);
        load_data  = resp_valid ? r_load_data : '0;
        acc_err    = resp_valid & r_err;
        lsu_stall  = ((r_state == S_IDLE) & req_valid) | (r_state == S_REQ) | (r_state == S_WAIT);
    end

endmodule
